// File: rtl/mpu6050_read_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mpu6050_read_sequencer_if
//  Purpose  : Command/response bundle between the MPU6050 read sequencer and
//             the byte-level I2C engine it drives.
//  Revision : 1.0  initial release
// ============================================================================
interface mpu6050_read_sequencer_if;
    logic       i2c_done;
    logic [7:0] i2c_read_data;
    logic [7:0] i2c_config;
    logic [6:0] i2c_dev_addr;
    logic [7:0] i2c_reg_addr;
    logic [7:0] i2c_reg_data;

    modport master (
        input  i2c_done,
        input  i2c_read_data,
        output i2c_config,
        output i2c_dev_addr,
        output i2c_reg_addr,
        output i2c_reg_data
    );

    modport slave (
        output i2c_done,
        output i2c_read_data,
        input  i2c_config,
        input  i2c_dev_addr,
        input  i2c_reg_addr,
        input  i2c_reg_data
    );
endinterface
`default_nettype wire

// File: rtl/mpu6050_read_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mpu6050_read_sequencer
//  Purpose  : Initialises an MPU6050 over an I2C byte engine, then reads the
//             14-byte sensor block periodically and publishes it atomically.
//  Revision : 1.0  initial release
// ============================================================================
module mpu6050_read_sequencer #(
    parameter logic [6:0]  DEV_ADDR       = 7'h68,
    parameter int unsigned PWRUP_CYCLES   = 1200000,
    parameter int unsigned GAP_CYCLES     = 240,
    parameter int unsigned TIMEOUT_CYCLES = 240000,
    parameter int unsigned SAMPLE_CYCLES  = 120000
) (
    input  wire logic                clk_12m,
    input  wire logic                rst_n,
    input  wire logic                enable,
    mpu6050_read_sequencer_if.master bus,
    output logic [15:0]              accel_x,
    output logic [15:0]              accel_y,
    output logic [15:0]              accel_z,
    output logic [15:0]              temp,
    output logic [15:0]              gyro_x,
    output logic [15:0]              gyro_y,
    output logic [15:0]              gyro_z,
    output logic                     data_valid,
    output logic                     init_done,
    output logic                     err
);

    localparam logic [7:0]  c_cfg_wait     = 8'h00;
    localparam logic [7:0]  c_cfg_write    = 8'h01;
    localparam logic [7:0]  c_cfg_read     = 8'h04;
    localparam logic [7:0]  c_read_base    = 8'h3B;
    localparam logic [3:0]  c_init_len     = 4'd5;
    localparam logic [3:0]  c_read_len     = 4'd14;
    localparam logic [31:0] c_pwrup_last   = 32'(PWRUP_CYCLES - 1);
    localparam logic [31:0] c_gap_last     = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_sample_last  = 32'(SAMPLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_CMD  = 3'd1,
        ST_INIT_WAIT = 3'd2,
        ST_GAP       = 3'd3,
        ST_READ_CMD  = 3'd4,
        ST_READ_WAIT = 3'd5,
        ST_PUBLISH   = 3'd6,
        ST_IDLE      = 3'd7
    } state_t;

    // {register, value} pairs: wake, sample divider, DLPF, gyro FS, accel FS
    function automatic logic [15:0] init_entry(input logic [3:0] idx);
        logic [15:0] entry;
        case (idx)
            4'd0:    entry = 16'h6B00;
            4'd1:    entry = 16'h1907;
            4'd2:    entry = 16'h1A06;
            4'd3:    entry = 16'h1B18;
            4'd4:    entry = 16'h1C01;
            default: entry = 16'h6B00;
        endcase
        return entry;
    endfunction

    state_t      state_q;
    logic [31:0] wait_cnt_q;
    logic [31:0] sample_cnt_q;
    logic [3:0]  idx_q;
    logic        in_read_q;
    logic        done_meta_q;
    logic        done_sync_q;
    logic        done_prev_q;
    logic [7:0]  shadow_q [14];

    logic        done_evt;
    logic        timeout_hit;
    logic [15:0] init_next;

    assign done_evt    = done_sync_q & ~done_prev_q;
    assign timeout_hit = ((state_q == ST_INIT_WAIT) || (state_q == ST_READ_WAIT))
                         && !done_evt && (wait_cnt_q == c_timeout_last);
    assign init_next   = init_entry(idx_q);

    assign bus.i2c_dev_addr = DEV_ADDR;

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_PWRUP;
            wait_cnt_q       <= 32'd0;
            sample_cnt_q     <= 32'd0;
            idx_q            <= 4'd0;
            in_read_q        <= 1'b0;
            done_meta_q      <= 1'b0;
            done_sync_q      <= 1'b0;
            done_prev_q      <= 1'b0;
            for (int i = 0; i < 14; i++) shadow_q[i] <= 8'h00;
            bus.i2c_config   <= c_cfg_wait;
            bus.i2c_reg_addr <= 8'h00;
            bus.i2c_reg_data <= 8'h00;
            accel_x          <= 16'h0000;
            accel_y          <= 16'h0000;
            accel_z          <= 16'h0000;
            temp             <= 16'h0000;
            gyro_x           <= 16'h0000;
            gyro_y           <= 16'h0000;
            gyro_z           <= 16'h0000;
            data_valid       <= 1'b0;
            init_done        <= 1'b0;
            err              <= 1'b0;
        end else begin
            done_meta_q <= bus.i2c_done;
            done_sync_q <= done_meta_q;
            done_prev_q <= done_sync_q;
            data_valid  <= 1'b0;

            // Sample period is measured from the last burst start and saturates
            if (sample_cnt_q != c_sample_last) sample_cnt_q <= sample_cnt_q + 32'd1;

            if (timeout_hit) begin
                err            <= 1'b1;
                init_done      <= 1'b0;
                in_read_q      <= 1'b0;
                idx_q          <= 4'd0;
                wait_cnt_q     <= 32'd0;
                bus.i2c_config <= c_cfg_wait;
                for (int i = 0; i < 14; i++) shadow_q[i] <= 8'h00;
                state_q        <= ST_GAP;
            end else begin
                case (state_q)
                    ST_PWRUP: begin
                        bus.i2c_config <= c_cfg_wait;
                        if (wait_cnt_q == c_pwrup_last) begin
                            wait_cnt_q       <= 32'd0;
                            idx_q            <= 4'd0;
                            in_read_q        <= 1'b0;
                            bus.i2c_config   <= c_cfg_write;
                            bus.i2c_reg_addr <= init_next[15:8];
                            bus.i2c_reg_data <= init_next[7:0];
                            state_q          <= ST_INIT_CMD;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 32'd1;
                        end
                    end
                    ST_INIT_CMD: begin
                        wait_cnt_q <= 32'd0;
                        state_q    <= ST_INIT_WAIT;
                    end
                    ST_INIT_WAIT: begin
                        if (done_evt) begin
                            idx_q          <= idx_q + 4'd1;
                            wait_cnt_q     <= 32'd0;
                            bus.i2c_config <= c_cfg_wait;
                            state_q        <= ST_GAP;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 32'd1;
                        end
                    end
                    ST_GAP: begin
                        if (wait_cnt_q == c_gap_last) begin
                            wait_cnt_q <= 32'd0;
                            if (in_read_q) begin
                                if (idx_q == c_read_len) begin
                                    state_q <= ST_PUBLISH;
                                end else begin
                                    bus.i2c_config   <= c_cfg_read;
                                    bus.i2c_reg_addr <= c_read_base + {4'h0, idx_q};
                                    bus.i2c_reg_data <= 8'h00;
                                    state_q          <= ST_READ_CMD;
                                end
                            end else if (idx_q == c_init_len) begin
                                init_done <= 1'b1;
                                state_q   <= ST_IDLE;
                            end else begin
                                bus.i2c_config   <= c_cfg_write;
                                bus.i2c_reg_addr <= init_next[15:8];
                                bus.i2c_reg_data <= init_next[7:0];
                                state_q          <= ST_INIT_CMD;
                            end
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 32'd1;
                        end
                    end
                    ST_READ_CMD: begin
                        wait_cnt_q <= 32'd0;
                        state_q    <= ST_READ_WAIT;
                    end
                    ST_READ_WAIT: begin
                        if (done_evt) begin
                            shadow_q[idx_q] <= bus.i2c_read_data;
                            idx_q           <= idx_q + 4'd1;
                            wait_cnt_q      <= 32'd0;
                            bus.i2c_config  <= c_cfg_wait;
                            state_q         <= ST_GAP;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 32'd1;
                        end
                    end
                    ST_PUBLISH: begin
                        accel_x    <= {shadow_q[0],  shadow_q[1]};
                        accel_y    <= {shadow_q[2],  shadow_q[3]};
                        accel_z    <= {shadow_q[4],  shadow_q[5]};
                        temp       <= {shadow_q[6],  shadow_q[7]};
                        gyro_x     <= {shadow_q[8],  shadow_q[9]};
                        gyro_y     <= {shadow_q[10], shadow_q[11]};
                        gyro_z     <= {shadow_q[12], shadow_q[13]};
                        data_valid <= 1'b1;
                        in_read_q  <= 1'b0;
                        idx_q      <= 4'd0;
                        state_q    <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if ((sample_cnt_q == c_sample_last) && enable) begin
                            sample_cnt_q     <= 32'd0;
                            in_read_q        <= 1'b1;
                            idx_q            <= 4'd0;
                            bus.i2c_config   <= c_cfg_read;
                            bus.i2c_reg_addr <= c_read_base;
                            bus.i2c_reg_data <= 8'h00;
                            state_q          <= ST_READ_CMD;
                        end
                    end
                    default: state_q <= ST_PWRUP;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mpu6050_read_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mpu6050_read_sequencer
//  Purpose  : Scoreboard bench: I2C engine model plus expected command and
//             publish queues for the MPU6050 read sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mpu6050_read_sequencer;

    localparam int P   = 40;
    localparam int G   = 6;
    localparam int T   = 150;
    localparam int S   = 1200;
    localparam int LAT = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    mpu6050_read_sequencer_if bus();
    logic [15:0] ax, ay, az, tp, gx, gy, gz;
    logic        dv, idone, err;
    logic [111:0] dut_words;
    assign dut_words = {ax, ay, az, tp, gx, gy, gz};

    mpu6050_read_sequencer #(
        .DEV_ADDR(7'h68), .PWRUP_CYCLES(P), .GAP_CYCLES(G),
        .TIMEOUT_CYCLES(T), .SAMPLE_CYCLES(S)
    ) dut (
        .clk_12m(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
        .accel_x(ax), .accel_y(ay), .accel_z(az), .temp(tp),
        .gyro_x(gx), .gyro_y(gy), .gyro_z(gz),
        .data_valid(dv), .init_done(idone), .err(err)
    );

    typedef struct {
        logic [7:0] cfg;
        logic [7:0] rg;
        logic [7:0] dat;
        int         gap;
    } cmd_t;

    cmd_t         exp_cmd [$];
    logic [111:0] exp_pub [$];
    logic [111:0] burst_q [$];
    logic [111:0] model_words = '0;
    logic [15:0]  init_tbl [5] = '{16'h6B00, 16'h1907, 16'h1A06, 16'h1B18, 16'h1C01};

    int n_cmp = 0, n_fail = 0;
    int n_cmd_exp = 0, n_pub_exp = 0, n_cmd_seen = 0, n_pub_seen = 0, rd_seen = 0;
    int spur_req = 0;
    bit withhold = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [7:0] cfg, input logic [7:0] rg,
                            input logic [7:0] dat, input int gap);
        cmd_t c;
        c.cfg = cfg; c.rg = rg; c.dat = dat; c.gap = gap;
        exp_cmd.push_back(c);
        n_cmd_exp++;
    endtask

    task automatic push_init(input int first_gap);
        for (int i = 0; i < 5; i++)
            push_cmd(8'h01, init_tbl[i][15:8], init_tbl[i][7:0], (i == 0) ? first_gap : G);
    endtask

    // Bytes b[k] answer register 3B+k; published words are {b0,b1}..{b12,b13}
    task automatic push_burst(input logic [111:0] b, input int nreads, input bit pub);
        logic [111:0] v;
        burst_q.push_back(b);
        for (int k = 0; k < nreads; k++)
            push_cmd(8'h04, 8'h3B + 8'(k), 8'h00, (k == 0) ? -1 : G);
        if (pub) begin
            for (int k = 0; k < 14; k++) v[111 - 8*k -: 8] = b[8*k +: 8];
            exp_pub.push_back(v);
            model_words = v;
            n_pub_exp++;
        end
    endtask

    function automatic logic [111:0] rand_burst();
        logic [111:0] b;
        for (int k = 0; k < 14; k++) b[8*k +: 8] = 8'($urandom_range(0, 255));
        return b;
    endfunction

    // ---------------- I2C engine model ----------------
    logic [7:0]   eng_prev_cfg;
    logic [7:0]   eng_resp;
    logic [111:0] eng_burst = '0;
    int eng_cd, eng_hold, eng_k, spur_ack = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            eng_prev_cfg      = 8'h00;
            eng_cd            = 0;
            eng_hold          = 0;
            bus.i2c_done      = 1'b0;
            bus.i2c_read_data = 8'h00;
        end else begin
            if (eng_prev_cfg == 8'h00 && bus.i2c_config != 8'h00) begin
                eng_resp = 8'h00;
                eng_cd   = LAT;
                if (bus.i2c_config == 8'h04) begin
                    eng_k = int'(bus.i2c_reg_addr) - 'h3B;
                    if (eng_k == 0) eng_burst = (burst_q.size() != 0) ? burst_q.pop_front() : '0;
                    if (eng_k >= 0 && eng_k < 14) eng_resp = eng_burst[8*eng_k +: 8];
                    if (withhold && eng_k == 5) eng_cd = 0;
                end
            end else if (eng_cd > 0) begin
                eng_cd--;
                if (eng_cd == 0) begin
                    bus.i2c_read_data = eng_resp;
                    bus.i2c_done      = 1'b1;
                    eng_hold          = 3;
                end
            end else if (eng_hold > 0) begin
                eng_hold--;
                if (eng_hold == 0) bus.i2c_done = 1'b0;
            end
            if (spur_ack != spur_req) begin
                spur_ack     = spur_req;
                bus.i2c_done = 1'b1;
                eng_hold     = 3;
            end
            eng_prev_cfg = bus.i2c_config;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [7:0] mon_prev_cfg;
    logic       mon_dv_prev;
    int         zero_run;
    cmd_t       mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev_cfg = 8'h00;
            mon_dv_prev  = 1'b0;
            zero_run     = 0;
        end else begin
            if (mon_prev_cfg == 8'h00 && bus.i2c_config != 8'h00) begin
                n_cmd_seen++;
                if (bus.i2c_config == 8'h04) rd_seen++;
                if (exp_cmd.size() == 0) begin
                    chk("unexpected_cmd", 128'({bus.i2c_config, bus.i2c_reg_addr, bus.i2c_reg_data}), 128'(0));
                end else begin
                    mon_e = exp_cmd.pop_front();
                    chk("cmd", 128'({bus.i2c_config, bus.i2c_reg_addr, bus.i2c_reg_data, bus.i2c_dev_addr}),
                        128'({mon_e.cfg, mon_e.rg, mon_e.dat, 7'h68}));
                    if (mon_e.gap >= 0) chk("gap_len", 128'(zero_run), 128'(mon_e.gap));
                end
                zero_run = 0;
            end else if (bus.i2c_config == 8'h00) begin
                zero_run++;
            end
            if (dv) begin
                n_pub_seen++;
                chk("dv_width", 128'(mon_dv_prev), 128'(0));
                if (exp_pub.size() == 0) chk("unexpected_pub", 128'(dv), 128'(0));
                else chk("pub_words", 128'(dut_words), 128'(exp_pub.pop_front()));
            end
            mon_prev_cfg = bus.i2c_config;
            mon_dv_prev  = dv;
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_rd(input int target, input string name);
        int g = 0;
        while (rd_seen < target && g < 6000) begin @(negedge clk); #1; g++; end
        chk(name, 128'(rd_seen >= target), 128'(1));
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while ((exp_cmd.size() != 0 || exp_pub.size() != 0) && g < 6000) begin @(negedge clk); #1; g++; end
        chk(name, 128'(exp_cmd.size() + exp_pub.size()), 128'(0));
    endtask

    task automatic wait_init(input string name);
        int g = 0;
        while (!idone && g < 3000) begin @(negedge clk); #1; g++; end
        chk(name, 128'(idone), 128'(1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cfg"},   128'({bus.i2c_config, bus.i2c_reg_addr, bus.i2c_reg_data}), 128'(0));
        chk({tag, "_dev"},   128'(bus.i2c_dev_addr), 128'(7'h68));
        chk({tag, "_words"}, 128'(dut_words), 128'(0));
        chk({tag, "_flags"}, 128'({dv, idone, err}), 128'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [111:0] fixed_b;
        int base, g;
        for (int k = 0; k < 14; k++) fixed_b[8*k +: 8] = 8'(k + 1);

        // Power-up, init table, first burst with bytes 01..0E
        enable = 1'b1;
        push_init(P - 1);
        push_burst(fixed_b, 14, 1'b1);
        @(negedge clk); #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_init("init_done_a");
        chk("init_cmd_count", 128'(n_cmd_seen), 128'(5));
        wait_rd(1, "burst_a_start");
        enable = 1'b0;
        wait_drain("drain_a");
        chk("accel_x", 128'(ax), 128'(16'h0102));
        chk("temp",    128'(tp), 128'(16'h0708));
        chk("gyro_z",  128'(gz), 128'(16'h0D0E));
        chk("err_a",   128'(err), 128'(0));

        // Spurious done while idle must do nothing
        spur_req++;
        repeat (30) @(negedge clk);
        #1;
        chk("spur_cmds", 128'(n_cmd_seen), 128'(n_cmd_exp));
        chk("spur_pubs", 128'(n_pub_seen), 128'(n_pub_exp));
        chk("spur_init", 128'(idone), 128'(1));

        // Two random bursts; enable dropped at read index 3 of the second
        base = rd_seen;
        push_burst(rand_burst(), 14, 1'b1);
        push_burst(rand_burst(), 14, 1'b1);
        enable = 1'b1;
        wait_rd(base + 18, "burst_c_idx3");
        enable = 1'b0;
        wait_drain("drain_c");
        repeat (2 * S) @(negedge clk);
        #1;
        chk("no_read_disabled", 128'(n_cmd_seen), 128'(n_cmd_exp));
        chk("pub_count_c",      128'(n_pub_seen), 128'(n_pub_exp));

        // Engine withholds done on read index 5 -> timeout and init replay
        withhold = 1'b1;
        base = rd_seen;
        push_burst(rand_burst(), 6, 1'b0);
        push_init(G);
        enable = 1'b1;
        wait_rd(base + 1, "burst_d_start");
        enable = 1'b0;
        wait_rd(base + 6, "burst_d_idx5");
        g = 0;
        while (!err && g < T + 50) begin @(negedge clk); #1; g++; end
        chk("timeout_latency", 128'(g), 128'(T + 1));
        chk("timeout_init_clr", 128'(idone), 128'(0));
        wait_init("init_done_d");
        wait_drain("drain_d");
        chk("err_sticky",       128'(err), 128'(1));
        chk("words_after_tmo",  128'(dut_words), 128'(model_words));
        chk("pub_count_d",      128'(n_pub_seen), 128'(n_pub_exp));
        withhold = 1'b0;

        // Asynchronous reset in the middle of a read wait
        base = rd_seen;
        push_burst(rand_burst(), 3, 1'b0);
        enable = 1'b1;
        wait_rd(base + 3, "burst_e_idx2");
        enable = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_words = '0;
        repeat (3) @(negedge clk);
        push_init(P - 1);
        #2 rst_n = 1'b1;
        wait_init("init_done_e");
        wait_drain("drain_e");
        chk("err_after_rst", 128'(err), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mpu6050_read_sequencer.md
MPU6050_READ_SEQUENCER -- requirements
Module: mpu6050_read_sequencer

Interface
REQ-001 Parameter DEV_ADDR, default 7'h68, is the MPU6050 7-bit slave address.
REQ-002 Parameter PWRUP_CYCLES, default 1200000, is the clk_12m cycles to wait after reset before the first command (100 ms).
REQ-003 Parameter GAP_CYCLES, default 240, is the cycles I2C_Wait is held between commands.
REQ-004 Parameter TIMEOUT_CYCLES, default 240000, is the cycles allowed per command before it is declared failed.
REQ-005 Parameter SAMPLE_CYCLES, default 120000, is the cycles from one burst start to the next (100 Hz).
REQ-006 clk_12m  in  1  system clock, 12 MHz, the only clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 enable  in  1  level; 1 allows new burst reads to start.
REQ-009 i2c_done  in  1  completion level from the I2C engine (its ACK-phase flag), asynchronous to clk_12m.
REQ-010 i2c_read_data  in  8  byte returned by the last single-read command.
REQ-011 i2c_config  out  8  engine mode: 8'h00 Wait, 8'h01 Single_Write_Byte, 8'h04 Single_Read_Byte.
REQ-012 i2c_dev_addr  out  7  slave address.
REQ-013 i2c_reg_addr  out  8  target register.
REQ-014 i2c_reg_data  out  8  write data.
REQ-015 accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z  out  16 each  latest sample, big-endian assembled {H,L}.
REQ-016 data_valid  out  1  one-cycle pulse when all seven words update.
REQ-017 init_done  out  1  level; high once the init table has completed.
REQ-018 err  out  1  sticky timeout flag; cleared only by reset.

Function
REQ-019 i2c_done SHALL pass a 2-flop synchronizer; a rising edge on the synchronized signal, the done event, SHALL mark command completion.
REQ-020 The FSM states SHALL be PWRUP, INIT_CMD, INIT_WAIT, GAP, READ_CMD, READ_WAIT, PUBLISH, IDLE.
REQ-021 PWRUP SHALL drive i2c_config=8'h00, count PWRUP_CYCLES, then go to INIT_CMD with table index 0.
REQ-022 The init table SHALL be written in order with Single_Write_Byte: (6B,00), (19,07), (1A,06), (1B,18), (1C,01).
REQ-023 INIT_CMD SHALL present config, DEV_ADDR, reg and data, then go to INIT_WAIT in the next cycle.
REQ-024 In INIT_WAIT, outputs SHALL be held until the done event; then the sequencer SHALL go to GAP.
REQ-025 GAP SHALL drive i2c_config=8'h00 for exactly GAP_CYCLES, then go to the next command; after the 5th init entry it SHALL set init_done and go to IDLE.
REQ-026 IDLE SHALL count SAMPLE_CYCLES since the previous burst start; at expiry with enable=1 it SHALL go to READ_CMD with read index 0; with enable=0 it SHALL stay in IDLE, counter saturated.
REQ-027 READ_CMD SHALL issue Single_Read_Byte at i2c_reg_addr = 8'h3B + index, for index 0..13, with i2c_reg_data = 8'h00.
REQ-028 In READ_WAIT, on the done event the sequencer SHALL capture i2c_read_data into shadow byte [index] in that same cycle, then go to GAP.
REQ-029 After index 13 is captured and its GAP completes, the sequencer SHALL go to PUBLISH.
REQ-030 PUBLISH SHALL copy all 14 shadow bytes to the seven outputs in one cycle (accel_x = {b0,b1} ... gyro_z = {b12,b13}) and pulse data_valid for exactly 1 cycle, then go to IDLE.
REQ-031 The outputs SHALL never show a partially updated burst.
REQ-032 A timeout counter SHALL run in INIT_WAIT and READ_WAIT; on reaching TIMEOUT_CYCLES without a done event the sequencer SHALL set err, discard the shadow bytes, clear init_done, and go to GAP then INIT_CMD index 0.
REQ-033 A done event outside INIT_WAIT or READ_WAIT SHALL be ignored.
REQ-034 Deasserting enable mid-burst SHALL NOT abort the burst; it only blocks the next burst.

Reset
REQ-035 While rst_n=0 the block SHALL return to PWRUP immediately, including mid-transaction.
REQ-036 Under reset, i2c_config, i2c_reg_addr, i2c_reg_data, all data words, data_valid, init_done, err and all counters SHALL be 0, and i2c_dev_addr SHALL be DEV_ADDR.

Verification
REQ-037 Scenario: reset release, enable=1, engine model pulses done 50 cycles after each command -> five writes in table order, each separated by GAP_CYCLES of 8'h00, then init_done=1.
REQ-038 Scenario: model returns bytes 8'h01..8'h0E for reg 3B..48 -> accel_x=16'h0102, temp=16'h0708, gyro_z=16'h0D0E, data_valid high 1 cycle.
REQ-039 Scenario: model withholds done on read index 5 -> err=1 after TIMEOUT_CYCLES, outputs unchanged, init table replayed from (6B,00).
REQ-040 Scenario: enable dropped at read index 3 -> burst completes and publishes; no further READ_CMD until enable=1.
REQ-041 Scenario: rst_n asserted during READ_WAIT -> all outputs 0 asynchronously; after release, PWRUP delay precedes the first write.
REQ-042 Scenario: spurious done event during IDLE -> no state change, no data_valid.
